// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment monitor: glyph table,
// tracking-state encoding and datapath widths.
package seg_pkg;

    localparam int SEG_W       = 7;
    localparam int DIGIT_W     = 4;
    localparam int STAB_CNT_W  = 4;
    localparam int TRANS_CNT_W = 16;
    localparam int ERR_CNT_W   = 8;

    // All segments off on an active-low bus.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit0=a .. bit6=g, indexed by hex value.
    localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    typedef enum logic {
        S_FIRST = 1'b0,
        S_TRACK = 1'b1
    } seg_state_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment pattern to hex value decoder.
module seg_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0]   pattern_i,
    output logic               legal_o,
    output logic [DIGIT_W-1:0] value_o
);

    // Table search; any pattern not in the table is illegal.
    always_comb begin
        legal_o = 1'b0;
        value_o = '0;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == GLYPH_TABLE[i]) begin
                legal_o = 1'b1;
                value_o = DIGIT_W'(i);
            end
        end
    end

endmodule

// File: rtl/seg_monitor.sv
// Seven-segment bus monitor: synchronizes and debounces the segment bus,
// decodes accepted glyphs and tracks up/down steps between digits.
//
// state   | meaning
// S_FIRST | no reference digit yet; next legal digit is taken without a step check
// S_TRACK | reference digit held in digit; each new legal digit is step-checked
module seg_monitor
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEG_W-1:0]       seg_in,
    input  logic                   clr,
    output logic [DIGIT_W-1:0]     digit,
    output logic                   digit_valid,
    output logic                   invalid,
    output logic                   dir_up,
    output logic                   dir_down,
    output logic                   step_err,
    output logic [TRANS_CNT_W-1:0] trans_cnt,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    localparam logic [STAB_CNT_W-1:0] STABLE_MAX = STAB_CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0]       sync1_q, sync2_q, prev_q, last_pat_q;
    logic [STAB_CNT_W-1:0]  stab_cnt_q, stab_cnt_d;
    seg_state_e             state_q;
    logic [DIGIT_W-1:0]     digit_q;
    logic                   dv_q, inv_q, up_q, dn_q, se_q;
    logic [TRANS_CNT_W-1:0] trans_q;
    logic [ERR_CNT_W-1:0]   err_q;

    logic                   stable, accept;
    logic                   dec_legal;
    logic [DIGIT_W-1:0]     dec_value;
    logic [DIGIT_W-1:0]     digit_plus, digit_minus;

    // Stability count: restart on any change of the synchronized sample.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (sync2_q != prev_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STABLE_MAX) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    // Judged on the counter's next value so the pattern is taken on the same
    // edge the count completes; last_pat_q stops a saturated count re-accepting.
    assign stable      = (stab_cnt_d == STABLE_MAX);
    assign accept      = stable && (sync2_q != last_pat_q);
    assign digit_plus  = digit_q + 1'b1;
    assign digit_minus = digit_q - 1'b1;

    seg_decode u_decode (
        .pattern_i (sync2_q),
        .legal_o   (dec_legal),
        .value_o   (dec_value)
    );

    // Two-flop synchronizer, previous-sample register and stability counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= SEG_BLANK;
            sync2_q    <= SEG_BLANK;
            prev_q     <= SEG_BLANK;
            stab_cnt_q <= '0;
        end else begin
            sync1_q    <= seg_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // Tracking FSM with registered outputs and saturating counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pat_q <= SEG_BLANK;
            state_q    <= S_FIRST;
            digit_q    <= '0;
            dv_q       <= 1'b0;
            inv_q      <= 1'b0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            se_q       <= 1'b0;
            trans_q    <= '0;
            err_q      <= '0;
        end else begin
            dv_q <= 1'b0;
            se_q <= 1'b0;
            // A pattern discarded by clr is still consumed, so it is not
            // picked up again on the following cycle.
            if (accept) begin
                last_pat_q <= sync2_q;
            end
            if (clr) begin
                state_q <= S_FIRST;
                up_q    <= 1'b0;
                dn_q    <= 1'b0;
                trans_q <= '0;
                err_q   <= '0;
            end else if (accept) begin
                if (!dec_legal) begin
                    inv_q <= 1'b1;
                    if (err_q != '1) err_q <= err_q + 1'b1;
                end else begin
                    inv_q   <= 1'b0;
                    digit_q <= dec_value;
                    dv_q    <= 1'b1;
                    case (state_q)
                        S_FIRST: state_q <= S_TRACK;
                        S_TRACK: begin
                            if (dec_value == digit_plus) begin
                                up_q <= 1'b1;
                                dn_q <= 1'b0;
                                if (trans_q != '1) trans_q <= trans_q + 1'b1;
                            end else if (dec_value == digit_minus) begin
                                up_q <= 1'b0;
                                dn_q <= 1'b1;
                                if (trans_q != '1) trans_q <= trans_q + 1'b1;
                            end else begin
                                se_q <= 1'b1;
                                if (err_q != '1) err_q <= err_q + 1'b1;
                            end
                        end
                        default: state_q <= S_FIRST;
                    endcase
                end
            end
        end
    end

    assign digit       = digit_q;
    assign digit_valid = dv_q;
    assign invalid     = inv_q;
    assign dir_up      = up_q;
    assign dir_down    = dn_q;
    assign step_err    = se_q;
    assign trans_cnt   = trans_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_seg_monitor.sv
// Bench for seg_monitor: a window-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seg_monitor;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  digit;
    logic        digit_valid, invalid, dir_up, dir_down, step_err;
    logic [15:0] trans_cnt;
    logic [7:0]  err_cnt;

    seg_monitor #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .clr         (clr),
        .digit       (digit),
        .digit_valid (digit_valid),
        .invalid     (invalid),
        .dir_up      (dir_up),
        .dir_down    (dir_down),
        .step_err    (step_err),
        .trans_cnt   (trans_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    logic [6:0] hx [32];
    logic [6:0] m_last = 7'h7F;
    int         m_digit = 0;
    int         m_tc = 0;
    int         m_ec = 0;
    bit         m_dv = 0, m_inv = 0, m_up = 0, m_dn = 0, m_se = 0, m_ref = 0;

    int n_dv = 0, n_se = 0, last_dv_cyc = -1;

    task automatic cmp(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic int glyph_value(logic [6:0] p);
        case (p)
            7'h40: return 0;   7'h79: return 1;   7'h24: return 2;   7'h30: return 3;
            7'h19: return 4;   7'h12: return 5;   7'h02: return 6;   7'h78: return 7;
            7'h00: return 8;   7'h10: return 9;   7'h08: return 10;  7'h03: return 11;
            7'h46: return 12;  7'h21: return 13;  7'h06: return 14;  7'h0E: return 15;
            default: return -1;
        endcase
    endfunction

    // Model: a pattern is taken when the S samples ending two edges ago all
    // match and differ from the last pattern taken.
    always @(posedge clk) begin
        bit run;
        bit acc;
        int v;
        cyc++;
        m_dv = 0;
        m_se = 0;
        if (!rst) begin
            for (int i = 0; i < 32; i++) hx[i] = 7'h7F;
            m_last = 7'h7F; m_digit = 0; m_inv = 0; m_up = 0; m_dn = 0;
            m_tc = 0; m_ec = 0; m_ref = 0;
        end else begin
            for (int i = 31; i > 0; i--) hx[i] = hx[i-1];
            hx[0] = seg_in;
            run = 1;
            for (int i = 3; i <= S + 1; i++) if (hx[i] != hx[2]) run = 0;
            acc = run && (hx[2] != m_last);
            if (acc) m_last = hx[2];
            if (clr) begin
                m_tc = 0; m_ec = 0; m_ref = 0; m_up = 0; m_dn = 0;
            end else if (acc) begin
                v = glyph_value(hx[2]);
                if (v < 0) begin
                    m_inv = 1;
                    if (m_ec < 255) m_ec++;
                end else begin
                    m_inv = 0;
                    m_dv  = 1;
                    if (m_ref) begin
                        if (v == (m_digit + 1) % 16) begin
                            m_up = 1; m_dn = 0;
                            if (m_tc < 65535) m_tc++;
                        end else if (v == (m_digit + 15) % 16) begin
                            m_up = 0; m_dn = 1;
                            if (m_tc < 65535) m_tc++;
                        end else begin
                            m_se = 1;
                            if (m_ec < 255) m_ec++;
                        end
                    end
                    m_ref   = 1;
                    m_digit = v;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        cmp("digit",       digit,       m_digit);
        cmp("digit_valid", digit_valid, m_dv);
        cmp("invalid",     invalid,     m_inv);
        cmp("dir_up",      dir_up,      m_up);
        cmp("dir_down",    dir_down,    m_dn);
        cmp("step_err",    step_err,    m_se);
        cmp("trans_cnt",   trans_cnt,   m_tc);
        cmp("err_cnt",     err_cnt,     m_ec);
        if (digit_valid) begin n_dv++; last_dv_cyc = cyc; end
        if (step_err) n_se++;
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic hold(logic [6:0] p, int n, output int set_cyc);
        seg_in  = p;
        set_cyc = cyc;
        tick(n);
    endtask

    initial begin
        int t, nv, ns;
        tick(3);
        cmp("rst_digit", digit, 0);
        cmp("rst_valid", digit_valid, 0);
        cmp("rst_trans", trans_cnt, 0);
        cmp("rst_err",   err_cnt, 0);
        rst = 1'b1;
        tick(2);

        // 0 then 1: latency and first up step
        hold(7'h40, 10, t);
        cmp("d0_latency", last_dv_cyc, t + 6);
        cmp("d0_digit", digit, 0);
        cmp("d0_dir_up", dir_up, 0);
        hold(7'h79, 10, t);
        cmp("d1_latency", last_dv_cyc, t + 6);
        cmp("d1_digit", digit, 1);
        cmp("d1_dir_up", dir_up, 1);
        cmp("d1_trans", trans_cnt, 1);

        // short glitch between identical stable periods
        nv = n_dv;
        hold(7'h24, 3, t);
        hold(7'h79, 10, t);
        cmp("glitch_dv", n_dv, nv);
        cmp("glitch_trans", trans_cnt, 1);
        cmp("glitch_err", err_cnt, 0);

        // F -> 0 -> F wrap-around
        clr = 1'b1; tick(1); clr = 1'b0;
        nv = n_dv;
        hold(7'h0E, 10, t);
        cmp("f_digit", digit, 15);
        cmp("f_dir_up", dir_up, 0);
        hold(7'h40, 10, t);
        cmp("f0_dir_up", dir_up, 1);
        cmp("f0_trans", trans_cnt, 1);
        hold(7'h0E, 10, t);
        cmp("0f_dir_down", dir_down, 1);
        cmp("0f_dir_up", dir_up, 0);
        cmp("0f_trans", trans_cnt, 2);
        cmp("wrap_dv_count", n_dv, nv + 3);

        // 0 -> 3 illegal step
        hold(7'h40, 10, t);
        ns = n_se;
        hold(7'h30, 10, t);
        cmp("step_err_pulse", n_se, ns + 1);
        cmp("step_err_cnt", err_cnt, 1);
        cmp("step_trans", trans_cnt, 3);
        cmp("step_digit", digit, 3);

        // 1 -> blank -> 2
        clr = 1'b1; tick(1); clr = 1'b0;
        hold(7'h79, 10, t);
        seg_in = 7'h7F;
        tick(8);
        cmp("blank_invalid", invalid, 1);
        cmp("blank_err", err_cnt, 1);
        cmp("blank_digit", digit, 1);
        tick(2);
        hold(7'h24, 10, t);
        cmp("after_blank_invalid", invalid, 0);
        cmp("after_blank_digit", digit, 2);
        cmp("after_blank_dir_up", dir_up, 1);
        cmp("after_blank_trans", trans_cnt, 1);

        // clr coincident with an acceptance
        nv = n_dv;
        seg_in = 7'h40;
        t = cyc;
        tick(5);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(4);
        cmp("clr_acc_dv", n_dv, nv);
        cmp("clr_acc_digit", digit, 2);
        cmp("clr_acc_trans", trans_cnt, 0);
        cmp("clr_acc_err", err_cnt, 0);
        cmp("clr_acc_dir_up", dir_up, 0);
        ns = n_se;
        hold(7'h79, 10, t);
        cmp("post_clr_latency", last_dv_cyc, t + 6);
        cmp("post_clr_digit", digit, 1);
        cmp("post_clr_dir_down", dir_down, 0);
        cmp("post_clr_step_err", n_se, ns);

        // reset in the middle of a stability count
        seg_in = 7'h24;
        tick(3);
        rst = 1'b0;
        tick(1);
        cmp("midrst_digit", digit, 0);
        cmp("midrst_invalid", invalid, 0);
        cmp("midrst_trans", trans_cnt, 0);
        rst = 1'b1;
        t = cyc;
        ns = n_se;
        tick(10);
        cmp("post_rst_latency", last_dv_cyc, t + 6);
        cmp("post_rst_digit", digit, 2);
        cmp("post_rst_dir_up", dir_up, 0);
        cmp("post_rst_step_err", n_se, ns);

        // err_cnt saturation with alternating illegal patterns
        for (int i = 0; i < 140; i++) begin
            hold(7'h7E, 5, t);
            hold(7'h7F, 5, t);
        end
        cmp("err_sat", err_cnt, 255);
        cmp("err_sat_invalid", invalid, 1);
        cmp("err_sat_digit", digit, 2);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_monitor.md
SEG_MONITOR -- requirements
Module: seg_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical synchronized samples needed to accept a pattern (legal range 2..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port seg_in, input, 7 bits: active-low seven-segment bus, bit0=a through bit6=g, asynchronous to clk.
REQ-005 SHALL have port clr, input, 1 bit: synchronous clear of the counters and of the tracking state.
REQ-006 SHALL have port digit, output, 4 bits: the last accepted hex value.
REQ-007 SHALL have port digit_valid, output, 1 bit: one-cycle pulse when a new digit is accepted.
REQ-008 SHALL have port invalid, output, 1 bit: high while the stable pattern is not a legal hex glyph.
REQ-009 SHALL have ports dir_up and dir_down, outputs, 1 bit each: direction of the last legal step; they are mutually exclusive.
REQ-010 SHALL have port step_err, output, 1 bit: one-cycle pulse on an illegal step.
REQ-011 SHALL have port trans_cnt, output, 16 bits: count of legal steps, saturating.
REQ-012 SHALL have port err_cnt, output, 8 bits: count of invalid-pattern events plus step errors, saturating.

Function
REQ-013 SHALL pass seg_in through a 2-flop synchronizer before any other use.
REQ-014 SHALL hold a stability counter that resets to 0 when the synchronized sample differs from the previous sample, and otherwise increments up to a saturation value of STABLE_CYCLES-1.
REQ-015 SHALL treat a pattern as stable when the stability counter equals STABLE_CYCLES-1.
REQ-016 SHALL accept a stable pattern once per change, and only when it differs from the last accepted pattern.
REQ-017 SHALL decode glyphs 0-F using the standard patterns, e.g. 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, F=7'h0E.
- Any other pattern is illegal.
REQ-018 SHALL, on acceptance of a legal glyph, update digit and pulse digit_valid exactly STABLE_CYCLES+2 rising edges after the first edge that samples the new seg_in.
REQ-019 SHALL, on acceptance of an illegal glyph:
- raise invalid;
- hold digit;
- increment err_cnt once;
- generate no digit_valid pulse.
REQ-020 SHALL keep invalid high until a legal glyph is accepted.
REQ-021 SHALL implement a state machine with two states:
- S_FIRST: no reference digit yet;
- S_TRACK: a reference digit exists.
REQ-022 SHALL, in S_FIRST, move to S_TRACK on the first legal acceptance, with no step check, no direction change and no count change.
REQ-023 SHALL, in S_TRACK, classify each new digit d against the previous digit p:
- d==p+1 mod 16: set dir_up, clear dir_down, increment trans_cnt;
- d==p-1 mod 16: set dir_down, clear dir_up, increment trans_cnt;
- otherwise: pulse step_err, increment err_cnt, leave direction unchanged.
In every case d becomes the new reference.
REQ-024 SHALL count wrap-around F->0 as up and 0->F as down.
REQ-025 SHALL use an illegal glyph only to set the invalid flag; it does not affect the reference, so the next legal digit is compared to the last legal digit.
REQ-026 SHALL saturate trans_cnt at 16'hFFFF and err_cnt at 8'hFF; neither counter wraps.
REQ-027 SHALL give clr priority over a same-cycle acceptance when clr is high:
- counters cleared;
- state set to S_FIRST;
- dir_up and dir_down cleared;
- the acceptance that cycle discarded;
- digit held.

Reset
REQ-028 SHALL, while rst is low, force:
- the synchronizer to 7'h7F (all segments off);
- the stability counter to 0;
- the last accepted pattern to 7'h7F;
- digit to 0;
- digit_valid, invalid, dir_up, dir_down and step_err to 0;
- both counters to 0;
- state to S_FIRST.
REQ-029 SHALL abandon any in-progress stability count when reset is asserted mid-operation; after release, a pattern needs the full STABLE_CYCLES+2 cycles to be accepted.

Structure
REQ-030 SHALL place the 16-entry glyph table, the state encoding (S_FIRST, S_TRACK) and the counter widths in a shared package, seg_pkg.
REQ-031 SHALL use exactly one sub-module, seg_decode: combinational 7-bit pattern to {legal, 4-bit value}.

Verification
REQ-032 SHALL verify: hold 7'h40 and then 7'h79, each for 10 cycles with STABLE_CYCLES=4 -> digit 0, then 1, each digit_valid 6 edges after its change; dir_up=1; trans_cnt=1.
REQ-033 SHALL verify: glitch 7'h24 for 3 cycles between two stable 7'h79 periods -> no digit_valid, no counter change.
REQ-034 SHALL verify: sequence F (7'h0E) -> 0 (7'h40) -> F -> digit_valid three times; dir_up after the second digit, dir_down after the third; trans_cnt=2.
REQ-035 SHALL verify: 0 -> 3 (7'h30) -> step_err pulse; err_cnt=1; trans_cnt unchanged.
REQ-036 SHALL verify: stable 7'h7F after digit 1, then 2 -> invalid high while 7'h7F is stable, err_cnt+1, then invalid low; 1->2 counted as up.
REQ-037 SHALL verify: assert clr in the same cycle as an acceptance, and separately assert rst mid-count -> all outputs at reset values; the next digit is treated as first (no step check).
